// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct codes, FSM states and a sign-handling helper.
package mdu_pkg;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    // Widest value the helper handles: a full 2*WIDTH product, WIDTH <= 64.
    localparam int XW = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    // Two's-complement negate when neg is set; with neg = sign bit this is |x|.
    // Callers zero-extend into XW bits and cast the result back to their width.
    function automatic logic [XW-1:0] cneg(input logic [XW-1:0] x,
                                           input logic neg);
        return neg ? (~x + XW'(1)) : x;
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the pipeline and the MDU.
// master = pipeline side, slave = MDU side.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, func, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, func, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring shift-subtract for divide, on the {hi,lo} accumulator.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nhi,
    output logic [WIDTH-1:0] nlo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rsh;
    logic [WIDTH:0] diff;

    // Multiply: add d into the upper half on lo[0], shift right.
    // Divide: shift remainder left, subtract d, keep it if no borrow.
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
        rsh  = {hi, lo[WIDTH-1]};
        diff = rsh - {1'b0, d};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                nhi = diff[WIDTH-1:0];
                nlo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                nhi = {hi[WIDTH-2:0], lo[WIDTH-1]};
                nlo = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nhi = sum[WIDTH:1];
            nlo = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO, plus MTHI/MTLO.
// Build option MDU_EARLY_EXIT_EN: zero operands skip the iterations.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst_n,
    mdu_iter_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ahi, alo, opnd;
    logic [WIDTH-1:0] nhi, nlo;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;
    logic             is_div, div0, neg_lo, neg_hi;

    logic             f_mul, f_div, f_sgn, f_mthi, f_mtlo;
    logic             go, early;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign f_mul  = (bus.func == F_MULT) || (bus.func == F_MULTU);
    assign f_div  = (bus.func == F_DIV) || (bus.func == F_DIVU);
    assign f_sgn  = (bus.func == F_MULT) || (bus.func == F_DIV);
    assign f_mthi = (bus.func == F_MTHI);
    assign f_mtlo = (bus.func == F_MTLO);
    assign go     = (state == IDLE) && bus.start && !bus.flush;

    assign abs_a = WIDTH'(cneg(XW'(bus.a), f_sgn & bus.a[WIDTH-1]));
    assign abs_b = WIDTH'(cneg(XW'(bus.b), f_sgn & bus.b[WIDTH-1]));

`ifdef MDU_EARLY_EXIT_EN
    assign early = f_div ? (bus.b == '0)
                         : ((bus.a == '0) || (bus.b == '0));
`else
    assign early = 1'b0;
`endif

    // Sign fix-up of the unsigned magnitude result.
    assign prod   = PW'(cneg(XW'({ahi, alo}), neg_lo));
    assign fix_hi = is_div ? WIDTH'(cneg(XW'(ahi), neg_hi))
                           : prod[PW-1:WIDTH];
    assign fix_lo = is_div ? (div0 ? '1 : WIDTH'(cneg(XW'(alo), neg_lo)))
                           : prod[WIDTH-1:0];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .hi     (ahi),
        .lo     (alo),
        .d      (opnd),
        .nhi    (nhi),
        .nlo    (nlo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state; flush wins over both RUN progress and FIX.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (go && (f_mul || f_div))
                      state_n = early ? FIX : RUN;
            RUN:  if (bus.flush)
                      state_n = IDLE;
                  else if (cnt == CW'(WIDTH - 1))
                      state_n = FIX;
            FIX:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand latch, iteration, and HI/LO/done update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            ahi    <= '0;
            alo    <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (go) begin
                    if (f_mthi) hi_q <= bus.a;
                    if (f_mtlo) lo_q <= bus.a;
                    if (f_mul || f_div) begin
                        cnt    <= '0;
                        is_div <= f_div;
                        div0   <= f_div && (bus.b == '0);
                        neg_lo <= f_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_hi <= f_sgn & bus.a[WIDTH-1];
                        opnd   <= f_div ? abs_b : abs_a;
                        if (early) begin
                            ahi <= f_div ? abs_a : '0;
                            alo <= '0;
                        end else begin
                            ahi <= '0;
                            alo <= f_div ? abs_a : abs_b;
                        end
                    end
                end
                RUN: if (!bus.flush) begin
                    ahi <= nhi;
                    alo <= nlo;
                    cnt <= cnt + CW'(1);
                end
                FIX: if (!bus.flush) begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
